// File: rtl/sram_responder.sv
// Behavioural SRAM answering the SLC-3 active-low strobe bus. Reads become valid after
// RD_LAT sampled OE-low cycles, and writes commit after WR_LAT sampled WE-low cycles.
module sram_responder #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1,
  parameter int WR_LAT = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [15:0]       Data_in,
  input  logic              Mem_CE,
  input  logic              Mem_UB,
  input  logic              Mem_LB,
  input  logic              Mem_OE,
  input  logic              Mem_WE,
  input  logic              Init_en,
  input  logic [ADDR_W-1:0] Init_addr,
  input  logic [15:0]       Init_data,
  output logic [15:0]       Data_out,
  output logic              Data_valid,
  output logic              Write_ack,
  output logic              Conflict
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);
  localparam logic [2:0] WR_LAT_C = 3'(WR_LAT);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_VALID, WR_WAIT, WR_HOLD} state_t;

  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [2:0]          cnt_inc;
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         dout_q, dout_d;
  logic                dvalid_q, dvalid_d;
  logic                wack_q, conf_q;
  logic                sel, rd, wr, conflict, addr_same;
  logic                start_rd, start_wr, commit, init_ok;
  logic [15:0]         mem_q [0:DEPTH-1];

  // Lanes whose enable is released read back as zero.
  function automatic logic [15:0] lane_mask(input logic [15:0] w, input logic ub_n,
                                            input logic lb_n);
    return {(ub_n ? 8'h00 : w[15:8]), (lb_n ? 8'h00 : w[7:0])};
  endfunction

  assign sel       = ~Mem_CE;
  assign rd        = sel & ~Mem_OE & Mem_WE;
  assign wr        = sel & ~Mem_WE;
  assign conflict  = sel & ~Mem_OE & ~Mem_WE;
  assign addr_same = (ADDR == addr_q);
  assign cnt_inc   = {1'b0, cnt_q} + 3'd1;
  assign init_ok   = Init_en & ~sel & (state_q == IDLE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    commit   = 1'b0;
    start_rd = 1'b0;
    start_wr = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr)      start_wr = 1'b1;
        else if (rd) start_rd = 1'b1;
      end
      RD_WAIT: begin
        if (wr) start_wr = 1'b1;
        else if (rd) begin
          if (!addr_same)              cnt_d = 2'd1;
          else if (cnt_inc >= RD_LAT_C) state_d = RD_VALID;
          else                          cnt_d = cnt_inc[1:0];
        end else state_d = IDLE;
      end
      RD_VALID: begin
        if (wr) start_wr = 1'b1;
        else if (rd) begin
          if (!addr_same) begin
            state_d = RD_WAIT;
            cnt_d   = 2'd1;
          end
        end else state_d = IDLE;
      end
      WR_WAIT: begin
        if (wr) begin
          if (!addr_same) start_wr = 1'b1;
          else if (cnt_inc >= WR_LAT_C) begin
            commit  = 1'b1;
            state_d = WR_HOLD;
          end else cnt_d = cnt_inc[1:0];
        end else state_d = IDLE;
      end
      WR_HOLD: begin
        if (wr) begin
          if (!addr_same) begin
            state_d = WR_WAIT;
            cnt_d   = 2'd1;
          end
        end else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (start_wr) begin
      if (WR_LAT_C <= 3'd1) begin
        commit  = 1'b1;
        state_d = WR_HOLD;
      end else begin
        state_d = WR_WAIT;
        cnt_d   = 2'd1;
      end
    end else if (start_rd) begin
      if (RD_LAT_C <= 3'd1) state_d = RD_VALID;
      else begin
        state_d = RD_WAIT;
        cnt_d   = 2'd1;
      end
    end

    dvalid_d = (state_d == RD_VALID);
    dout_d   = dvalid_d ? lane_mask(mem_q[ADDR], Mem_UB, Mem_LB) : 16'h0000;
  end

  always_ff @(posedge Clk) begin
    addr_q <= ADDR;
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      wack_q   <= 1'b0;
      conf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      wack_q   <= commit;
      conf_q   <= conflict;
    end
  end

  // Array: bus commits and preload are mutually exclusive, and reset suppresses both.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (commit) begin
        if (!Mem_UB) mem_q[ADDR][15:8] <= Data_in[15:8];
        if (!Mem_LB) mem_q[ADDR][7:0]  <= Data_in[7:0];
      end else if (init_ok) begin
        mem_q[Init_addr] <= Init_data;
      end
    end
  end

  assign Data_out   = dout_q;
  assign Data_valid = dvalid_q;
  assign Write_ack  = wack_q;
  assign Conflict   = conf_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder (RD_LAT=1, WR_LAT=2): per-cycle expected outputs are
// queued with each stimulus step and compared after the following clock edge.
module tb_sram_responder;

  logic        Clk, Reset;
  logic [9:0]  ADDR, Init_addr;
  logic [15:0] Data_in, Init_data, Data_out;
  logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Init_en;
  logic        Data_valid, Write_ack, Conflict;

  typedef struct {
    string       tag;
    logic [15:0] dout;
    logic        vld;
    logic        ack;
    logic        cf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  sram_responder #(.ADDR_W(10), .RD_LAT(1), .WR_LAT(2)) dut (
    .Clk(Clk), .Reset(Reset), .ADDR(ADDR), .Data_in(Data_in),
    .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
    .Init_en(Init_en), .Init_addr(Init_addr), .Init_data(Init_data),
    .Data_out(Data_out), .Data_valid(Data_valid), .Write_ack(Write_ack), .Conflict(Conflict)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one bus cycle, queue what the outputs must be after the edge, then compare.
  task automatic step(input string tag, input logic ce, input logic oe, input logic we,
                      input logic ub, input logic lb, input logic [9:0] a,
                      input logic [15:0] d, input logic [15:0] e_do, input logic e_v,
                      input logic e_ack, input logic e_cf);
    exp_t e;
    Mem_CE = ce; Mem_OE = oe; Mem_WE = we; Mem_UB = ub; Mem_LB = lb;
    ADDR = a; Data_in = d;
    e.tag = tag; e.dout = e_do; e.vld = e_v; e.ack = e_ack; e.cf = e_cf;
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
    e = exp_q.pop_front();
    check({e.tag, ".dout"}, Data_out, e.dout);
    check({e.tag, ".vld"}, {15'd0, Data_valid}, {15'd0, e.vld});
    check({e.tag, ".ack"}, {15'd0, Write_ack}, {15'd0, e.ack});
    check({e.tag, ".cf"}, {15'd0, Conflict}, {15'd0, e.cf});
  endtask

  task automatic idle(input string tag);
    step(tag, 1, 1, 1, 0, 0, 10'd0, 16'h0000, 16'h0000, 0, 0, 0);
  endtask

  task automatic preload(input logic [9:0] a, input logic [15:0] d);
    Init_en = 1'b1; Init_addr = a; Init_data = d;
    idle("init");
    Init_en = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Init_en = 1'b0; Init_addr = '0; Init_data = '0;
    idle("reset");
    idle("reset2");
    Reset = 1'b0;

    preload(10'd5, 16'h1234);
    preload(10'd3, 16'hAAAA);
    preload(10'd6, 16'h6666);

    // Preload + read; a preload attempted while the bus is selected must be ignored.
    Init_en = 1'b1; Init_addr = 10'd5; Init_data = 16'hFFFF;
    step("rd5_c1", 0, 0, 1, 0, 0, 10'd5, 16'h0, 16'h1234, 1, 0, 0);
    Init_en = 1'b0;
    step("rd5_c2", 0, 0, 1, 0, 0, 10'd5, 16'h0, 16'h1234, 1, 0, 0);
    idle("rd5_end");

    // Full write, then read back.
    step("wr9_c1", 0, 1, 0, 0, 0, 10'd9, 16'hBEEF, 16'h0, 0, 0, 0);
    step("wr9_c2", 0, 1, 0, 0, 0, 10'd9, 16'hBEEF, 16'h0, 0, 1, 0);
    idle("wr9_end");
    step("rd9", 0, 0, 1, 0, 0, 10'd9, 16'h0, 16'hBEEF, 1, 0, 0);
    idle("rd9_end");

    // WE held 4 cycles: exactly one commit.
    step("wr7_c1", 0, 1, 0, 0, 0, 10'd7, 16'h1111, 16'h0, 0, 0, 0);
    step("wr7_c2", 0, 1, 0, 0, 0, 10'd7, 16'h1111, 16'h0, 0, 1, 0);
    step("wr7_c3", 0, 1, 0, 0, 0, 10'd7, 16'h1111, 16'h0, 0, 0, 0);
    step("wr7_c4", 0, 1, 0, 0, 0, 10'd7, 16'h1111, 16'h0, 0, 0, 0);
    idle("wr7_end");
    step("rd7", 0, 0, 1, 0, 0, 10'd7, 16'h0, 16'h1111, 1, 0, 0);
    idle("rd7_end");

    // Byte lanes: lower-lane write, then full and masked reads.
    step("wr3_c1", 0, 1, 0, 1, 0, 10'd3, 16'h5555, 16'h0, 0, 0, 0);
    step("wr3_c2", 0, 1, 0, 1, 0, 10'd3, 16'h5555, 16'h0, 0, 1, 0);
    idle("wr3_end");
    step("rd3_full", 0, 0, 1, 0, 0, 10'd3, 16'h0, 16'hAA55, 1, 0, 0);
    step("rd3_ub", 0, 0, 1, 0, 1, 10'd3, 16'h0, 16'hAA00, 1, 0, 0);
    idle("rd3_end");

    // No lanes enabled: acknowledged but array untouched.
    step("wr6n_c1", 0, 1, 0, 1, 1, 10'd6, 16'h0000, 16'h0, 0, 0, 0);
    step("wr6n_c2", 0, 1, 0, 1, 1, 10'd6, 16'h0000, 16'h0, 0, 1, 0);
    idle("wr6n_end");

    // Aborted writes to address 5.
    step("ab_we1", 0, 1, 0, 0, 0, 10'd5, 16'hDEAD, 16'h0, 0, 0, 0);
    step("ab_we1_rel", 0, 1, 1, 0, 0, 10'd5, 16'hDEAD, 16'h0, 0, 0, 0);
    step("ab_ce_c1", 0, 1, 0, 0, 0, 10'd5, 16'hDEAD, 16'h0, 0, 0, 0);
    step("ab_ce_c2", 1, 1, 0, 0, 0, 10'd5, 16'hDEAD, 16'h0, 0, 0, 0);
    Reset = 1'b1;
    step("ab_rst_c1", 0, 1, 0, 0, 0, 10'd5, 16'hDEAD, 16'h0, 0, 0, 0);
    Reset = 1'b0;
    step("ab_rst_c2", 0, 1, 0, 0, 0, 10'd5, 16'hDEAD, 16'h0, 0, 0, 0);
    idle("ab_end");
    step("rd5_after", 0, 0, 1, 0, 0, 10'd5, 16'h0, 16'h1234, 1, 0, 0);
    idle("rd5a_end");

    // Conflict on the first write cycle: pulses, write still commits, no read data.
    step("cf_c1", 0, 0, 0, 0, 0, 10'd10, 16'hC0DE, 16'h0, 0, 0, 1);
    step("cf_c2", 0, 1, 0, 0, 0, 10'd10, 16'hC0DE, 16'h0, 0, 1, 0);
    idle("cf_end");
    step("rd10", 0, 0, 1, 0, 0, 10'd10, 16'h0, 16'hC0DE, 1, 0, 0);
    idle("rd10_end");

    // Address change mid-read: one invalid cycle, then the new word.
    step("ac_a5", 0, 0, 1, 0, 0, 10'd5, 16'h0, 16'h1234, 1, 0, 0);
    step("ac_a6_c1", 0, 0, 1, 0, 0, 10'd6, 16'h0, 16'h0000, 0, 0, 0);
    step("ac_a6_c2", 0, 0, 1, 0, 0, 10'd6, 16'h0, 16'h6666, 1, 0, 0);

    // CE released with OE still low forces idle.
    step("ce_abort", 1, 0, 1, 0, 0, 10'd6, 16'h0, 16'h0000, 0, 0, 0);

    // Reset during a valid read clears the outputs.
    step("rr_rd", 0, 0, 1, 0, 0, 10'd9, 16'h0, 16'hBEEF, 1, 0, 0);
    Reset = 1'b1;
    step("rr_rst", 0, 0, 1, 0, 0, 10'd9, 16'h0, 16'h0000, 0, 0, 0);
    Reset = 1'b0;
    idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
